// File: rtl/toggle_bank_pkg.sv
// Shared types and helpers for the toggle bank controller: FSM state
// encoding, default sizing and the round-robin index arithmetic.
package toggle_bank_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int MAX_REQ     = 8;
  localparam int IDX_W       = 3;
  localparam int STATE_W     = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    ACK   = 2'd2
  } state_e;

  // First requester with req high, searching ptr, ptr+1, ... wrapping at n.
  // The loop walks the search order backwards so the earliest hit wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr,
                                               input int                 n);
    int idx;
    rr_pick = ptr;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = int'(ptr) + k;
        if (idx >= n) idx = idx - n;
        if (req[idx[IDX_W-1:0]]) rr_pick = idx[IDX_W-1:0];
      end
    end
  endfunction

  // Index following idx, wrapping at n.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx,
                                               input int               n);
    rr_next = (int'(idx) + 1 >= n) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/toggle_bank_ctrl_tff_slice.sv
// One bit of the toggle bank: a T flip-flop with synchronous clear and
// asynchronous active-low reset. Clear takes priority over the toggle.
module tff_slice (
  input  logic clk,
  input  logic rstn,
  input  logic t_i,
  input  logic clr_i,
  output logic q_o,
  output logic q_bar_o
);

  logic q_q;

  // Bit state: reset/clear to 0, otherwise invert when T is high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_q <= 1'b0;
    end else if (clr_i) begin
      q_q <= 1'b0;
    end else if (t_i) begin
      q_q <= ~q_q;
    end
  end

  assign q_o     = q_q;
  assign q_bar_o = ~q_q;

endmodule

// File: rtl/toggle_bank_ctrl.sv
// Round-robin controller sharing a WIDTH-bit toggle bank between NUM_REQ
// requesters. Each transaction is IDLE -> APPLY -> ACK: the winner's mask
// drives the T inputs for the APPLY cycle only, then a one-cycle grant
// is issued in ACK and the priority pointer moves past the winner.
module toggle_bank_ctrl
  import toggle_bank_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] mask,
  input  logic                     hold,
  input  logic                     clr,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     busy,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         q_bar
);

  state_e               state_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [IDX_W-1:0]     win_q;
  logic [IDX_W-1:0]     win_d;
  logic [WIDTH-1:0]     mask_q;
  logic [WIDTH-1:0]     mask_d;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [NUM_REQ-1:0]   gnt_d;
  logic [MAX_REQ-1:0]   req_ext;
  logic [WIDTH-1:0]     t_vec;
  logic                 any_req;

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  // Arbitration candidate, its mask, the grant decode of the latched
  // winner, and the T vector (non-zero only while in APPLY).
  always_comb begin
    int sel;
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    any_req                = |req;
    win_d                  = rr_pick(req_ext, ptr_q, NUM_REQ);
    sel                    = int'(win_d) * WIDTH;
    mask_d                 = mask[sel +: WIDTH];
    gnt_d                  = ONE_HOT0 << win_q;
    t_vec                  = (state_q == APPLY) ? mask_q : '0;
  end

  // Transaction FSM with registered grant; hold only gates the IDLE start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      mask_q  <= '0;
      gnt_q   <= '0;
    end else begin
      gnt_q <= '0;
      case (state_q)
        IDLE: begin
          if (!hold && any_req) begin
            win_q   <= win_d;
            mask_q  <= mask_d;
            state_q <= APPLY;
          end
        end
        APPLY: begin
          gnt_q   <= gnt_d;
          state_q <= ACK;
        end
        ACK: begin
          ptr_q   <= rr_next(win_q, NUM_REQ);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign busy = (state_q != IDLE);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bank
    tff_slice u_bit (
      .clk     (clk),
      .rstn    (rstn),
      .t_i     (t_vec[g]),
      .clr_i   (clr),
      .q_o     (q[g]),
      .q_bar_o (q_bar[g])
    );
  end

endmodule

// File: tb/tb_toggle_bank_ctrl.sv
// Directed bench for toggle_bank_ctrl (NUM_REQ=4, WIDTH=8): a vector table
// of whole transactions plus hand sequences for reset and hold.
module tb_toggle_bank_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req;
  logic [31:0] mask;
  logic        hold;
  logic        clr;
  logic [3:0]  gnt;
  logic        busy;
  logic [7:0]  q;
  logic [7:0]  q_bar;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_prev;

  toggle_bank_ctrl #(.NUM_REQ(4), .WIDTH(8)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .req   (req),
    .mask  (mask),
    .hold  (hold),
    .clr   (clr),
    .gnt   (gnt),
    .busy  (busy),
    .q     (q),
    .q_bar (q_bar)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] mask;
    bit          clr_pre;
    bit          clr_apply;
    logic [3:0]  gnt;
    logic [7:0]  q;
  } vec_t;

  vec_t tbl[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full transaction: start, APPLY, ACK, back to IDLE.
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    if (v.clr_pre) begin
      clr = 1'b1;
      tick();
      clr = 1'b0;
      exp_prev = 8'h00;
    end
    req  = v.req;
    mask = v.mask;
    tick();
    chk({tag, " apply busy"}, {31'd0, busy}, 32'd1);
    chk({tag, " apply gnt"}, {28'd0, gnt}, 32'd0);
    chk({tag, " apply q"}, {24'd0, q}, {24'd0, exp_prev});
    if (v.clr_apply) clr = 1'b1;
    tick();
    clr = 1'b0;
    chk({tag, " ack q"}, {24'd0, q}, {24'd0, v.q});
    chk({tag, " ack q_bar"}, {24'd0, q_bar}, {24'd0, ~v.q});
    chk({tag, " ack gnt"}, {28'd0, gnt}, {28'd0, v.gnt});
    chk({tag, " ack busy"}, {31'd0, busy}, 32'd1);
    req = 4'b0000;
    tick();
    chk({tag, " idle gnt"}, {28'd0, gnt}, 32'd0);
    chk({tag, " idle busy"}, {31'd0, busy}, 32'd0);
    exp_prev = v.q;
  endtask

  initial begin
    vec_t pre;
    // Starting from ptr=0, q=0 after the mid-APPLY reset.
    tbl[0]  = '{4'b0001, 32'h000000A5, 1'b0, 1'b0, 4'b0001, 8'hA5};
    tbl[1]  = '{4'b1000, 32'hA5000000, 1'b0, 1'b0, 4'b1000, 8'h00};
    tbl[2]  = '{4'b1111, 32'h08040201, 1'b0, 1'b0, 4'b0001, 8'h01};
    tbl[3]  = '{4'b1111, 32'h08040201, 1'b0, 1'b0, 4'b0010, 8'h03};
    tbl[4]  = '{4'b1101, 32'h08040201, 1'b0, 1'b0, 4'b0100, 8'h07};
    tbl[5]  = '{4'b1001, 32'h08040201, 1'b0, 1'b0, 4'b1000, 8'h0F};
    tbl[6]  = '{4'b0001, 32'h08040201, 1'b0, 1'b0, 4'b0001, 8'h0E};
    tbl[7]  = '{4'b1001, 32'h08040201, 1'b0, 1'b0, 4'b1000, 8'h06};
    tbl[8]  = '{4'b1001, 32'h08040201, 1'b0, 1'b0, 4'b0001, 8'h07};
    tbl[9]  = '{4'b0100, 32'h00FF0000, 1'b1, 1'b0, 4'b0100, 8'hFF};
    tbl[10] = '{4'b0100, 32'h00FF0000, 1'b0, 1'b0, 4'b0100, 8'h00};
    tbl[11] = '{4'b0010, 32'h00003C00, 1'b0, 1'b0, 4'b0010, 8'h3C};
    tbl[12] = '{4'b0100, 32'h00000000, 1'b0, 1'b0, 4'b0100, 8'h3C};
    tbl[13] = '{4'b0010, 32'h00000F00, 1'b0, 1'b1, 4'b0010, 8'h00};

    rstn = 1'b0;
    req  = 4'b0000;
    mask = 32'h0;
    hold = 1'b0;
    clr  = 1'b0;
    exp_prev = 8'h00;
    tick();
    tick();
    chk("rst q", {24'd0, q}, 32'h00);
    chk("rst q_bar", {24'd0, q_bar}, 32'hFF);
    chk("rst gnt", {28'd0, gnt}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    rstn = 1'b1;
    tick();

    // Make q non-zero, then reset in the middle of the next APPLY.
    pre = '{4'b0001, 32'h000000C3, 1'b0, 1'b0, 4'b0001, 8'hC3};
    run_vec(pre, 100);
    req  = 4'b0010;
    mask = 32'h00000F00;
    tick();
    chk("pre-rst busy", {31'd0, busy}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("async rst q", {24'd0, q}, 32'h00);
    chk("async rst q_bar", {24'd0, q_bar}, 32'hFF);
    chk("async rst gnt", {28'd0, gnt}, 32'd0);
    chk("async rst busy", {31'd0, busy}, 32'd0);
    req = 4'b0000;
    tick();
    rstn = 1'b1;
    tick();
    chk("post-rst gnt", {28'd0, gnt}, 32'd0);
    exp_prev = 8'h00;

    for (int i = 0; i < 14; i++) run_vec(tbl[i], i);

    // hold blocks the start while a request waits.
    hold = 1'b1;
    req  = 4'b1000;
    mask = 32'h55000000;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("hold busy c%0d", i), {31'd0, busy}, 32'd0);
      chk($sformatf("hold gnt c%0d", i), {28'd0, gnt}, 32'd0);
    end
    hold = 1'b0;
    tick();
    chk("unhold busy", {31'd0, busy}, 32'd1);
    hold = 1'b1;
    tick();
    chk("hold-apply q", {24'd0, q}, 32'h55);
    chk("hold-apply gnt", {28'd0, gnt}, 32'h8);
    req = 4'b0000;
    tick();
    chk("hold-apply end gnt", {28'd0, gnt}, 32'd0);
    chk("hold-apply end busy", {31'd0, busy}, 32'd0);
    hold = 1'b0;
    tick();
    chk("final q", {24'd0, q}, 32'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/toggle_bank_ctrl.md
# toggle_bank_ctrl

Controller that owns a WIDTH-bit bank of toggle flip-flops and shares it between NUM_REQ requesters. Each requester presents a toggle mask with a level request; a round-robin arbiter picks one, a three-state FSM applies the mask as the T inputs for exactly one cycle, then acknowledges the winner with a one-cycle grant. The block sits between the control agents and the toggle-register datapath and is the only writer of that register.

## Interface

- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 8, width of the toggle bank
- clk  in  1  clock, all state updates on rising edge
- rstn  in  1  one clock; reset is asynchronous and active-low (rstn=0 resets immediately, independent of clk)
- req  in  NUM_REQ  level request per requester; held high until its gnt bit is seen
- mask  in  NUM_REQ*WIDTH  toggle mask, requester i in bits [i*WIDTH +: WIDTH]; stable while req[i] high
- hold  in  1  blocks start of new transactions; an in-flight one completes
- clr  in  1  synchronous clear of the bank
- gnt  out  NUM_REQ  one-hot, one-cycle acknowledge
- busy  out  1  high whenever state is not IDLE
- q  out  WIDTH  toggle bank state
- q_bar  out  WIDTH  bitwise ~q

## Operation

- States: IDLE, APPLY, ACK.
- IDLE: if hold=0 and any req bit high, select winner = first requester with req high searching ptr, ptr+1, ... mod NUM_REQ; latch winner index and its mask; go APPLY. Otherwise stay.
- APPLY: T inputs of the bank = latched mask for this cycle only; each bit with mask=1 inverts at the closing edge, mask=0 bits hold. Go ACK.
- ACK: gnt[winner]=1 for this cycle; ptr <= (winner+1) mod NUM_REQ at closing edge; go IDLE. ACK never starts a new transaction.
- Outside APPLY all T inputs are 0; q holds.
- clr=1 at an edge: q <= 0 at that edge, overriding any toggle; if in APPLY, the toggle is discarded but FSM still proceeds to ACK and gnt is still issued.
- Zero mask: normal transaction, gnt issued, q unchanged.
- hold sampled only in IDLE; hold rising during APPLY/ACK has no effect on that transaction.
- req dropped before gnt: transaction already latched still completes and grants; requester must ignore the stray gnt.
- Reset (rstn=0, any state, any cycle): state=IDLE, ptr=0, q=0 (q_bar all ones), gnt=0, busy=0, latched winner/mask=0. In-flight transaction is lost; requesters re-request after rstn=1.

## Timing

- req[i] high before edge k with FSM in IDLE and no higher-priority contender: APPLY during cycle k..k+1, q updated at edge k+1, gnt[i]=1 during cycle k+1..k+2, FSM back in IDLE after edge k+2.
- Minimum 3 cycles per transaction; peak throughput one mask per 3 cycles.
- Requester observes gnt at edge k+2 and deasserts req; IDLE next evaluates at edge k+3, so no double grant.
- q, q_bar, gnt, busy are registered or direct decodes of registered state; no combinational path from req/mask/hold/clr to any output.

## Structure

- Package toggle_bank_pkg: state enum (IDLE, APPLY, ACK), state width, default NUM_REQ/WIDTH constants, function for round-robin next-index computation.
- Sub-module tff_slice: one bank bit (T input, sync clr, async active-low rstn, outputs q/q_bar); instantiated WIDTH times via generate. FSM, arbiter and pointer live in the top.

## Test plan

- Reset: rstn=0 mid-APPLY -> q=0x00, q_bar=0xFF, gnt=0, busy=0 immediately; after release, single req[0] mask=0xA5 -> q=0xA5 one edge after APPLY, gnt=0001 for one cycle, 3-cycle transaction.
- Round-robin: req=1111, masks 0x01/0x02/0x04/0x08, all held until granted -> grants in order 0,1,2,3, final q=0x0F; req[0] re-asserted then -> next grant 0 only after 1..3 served.
- Double toggle: req[2] mask=0xFF twice -> q 0x00 -> 0xFF -> 0x00; zero mask -> gnt issued, q unchanged.
- clr in APPLY: q=0x3C, req[1] mask=0x0F with clr=1 during APPLY -> q=0x00, gnt[1] still pulses.
- hold: hold=1 with req[3] pending -> busy stays 0, no gnt for 10 cycles; hold=0 -> transaction starts next edge; hold raised during APPLY -> transaction completes.
- Pointer wrap with NUM_REQ=4: grant to 3 -> ptr=0; req=1001 -> next grant 0, then 3.
